// File: rtl/pq_pkg.sv
// Shared types for the priority-queue sort client: key/value entry, FSM states
// and the key ordering predicate.
package pq_pkg;

    localparam int KEY_W = 16;
    localparam int VAL_W = 16;

    typedef logic [KEY_W-1:0] key_t;

    typedef struct packed {
        key_t             key;
        logic [VAL_W-1:0] val;
    } kv_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        DRAIN
    } pq_client_state_t;

    // True when key breaks the required order relative to the previous key.
    function automatic logic key_out_of_order(input key_t key, input key_t prev,
                                              input logic min_first);
        return min_first ? (key < prev) : (key > prev);
    endfunction

endpackage

// File: rtl/pq_if.sv
// Handshake bundle between the sort client and a priority-queue device.
interface pq_if;
    import pq_pkg::*;

    logic ivalid;
    logic irdy;
    kv_t  idata;
    logic busy;
    logic full;
    logic ovalid;
    logic ordy;
    kv_t  odata;

    modport client (output ivalid, idata, ordy,
                    input  irdy, busy, full, ovalid, odata);
    modport device (input  ivalid, idata, ordy,
                    output irdy, busy, full, ovalid, odata);

endinterface

// File: rtl/pq_order_chk.sv
// Sticky monitor flagging a drained key stream that violates the sort order.
module pq_order_chk
    import pq_pkg::*;
#(
    parameter int MIN_FIRST = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic first,
    input  logic valid,
    input  key_t key,
    output logic err
);

    logic err_q;
    key_t prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q  <= 1'b0;
            prev_q <= '0;
        end else if (valid) begin
            prev_q <= key;
            if (!first && key_out_of_order(key, prev_q, MIN_FIRST != 0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;

endmodule

// File: rtl/pq_sort_client.sv
// Loads an upstream batch into a priority-queue device, waits for it to settle,
// then drains it downstream in key order while checking that order.
module pq_sort_client
    import pq_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MIN_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    pq_if.client        pq,
    input  logic        s_valid,
    output logic        s_ready,
    input  kv_t         s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output kv_t         m_data,
    output logic        m_last,
    output logic [15:0] batch_cnt,
    output logic        order_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pq_client_state_t state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      batch_q, batch_d;
    logic             first_q, first_d;
    logic             chk_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            batch_q <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            batch_q <= batch_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        batch_d   = batch_q;
        first_d   = first_q;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        pq.ivalid = 1'b0;
        pq.ordy   = 1'b0;
        pq.idata  = s_data;
        m_data    = pq.odata;

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pq.ivalid = s_valid && !pq.full;
                s_ready   = pq.irdy && !pq.full;
                if (s_valid && s_ready) begin
                    count_d = count_q + 1'b1;
                    if (s_last || count_d == CNT_MAX) begin
                        state_d = SETTLE;
                    end
                end else if (pq.full && count_q != '0) begin
                    // Device filled up: drain what we have, rest is next batch.
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                first_d = 1'b1;
                if (!pq.busy) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                m_valid = pq.ovalid;
                pq.ordy = m_ready;
                m_last  = pq.ovalid && (count_q == 1);
                if (pq.ovalid && m_ready) begin
                    first_d = 1'b0;
                    count_d = count_q - 1'b1;
                    if (count_q == 1) begin
                        state_d = IDLE;
                        batch_d = batch_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshakes stay quiet while reset is held, whatever the old state.
        if (!rst) begin
            s_ready   = 1'b0;
            m_valid   = 1'b0;
            m_last    = 1'b0;
            pq.ivalid = 1'b0;
            pq.ordy   = 1'b0;
        end
    end

    assign chk_valid = m_valid && m_ready;
    assign batch_cnt = batch_q;

    pq_order_chk #(
        .MIN_FIRST (MIN_FIRST)
    ) u_order_chk (
        .clk   (clk),
        .rst   (rst),
        .first (first_q),
        .valid (chk_valid),
        .key   (pq.odata.key),
        .err   (order_err)
    );

endmodule
